controle_multiciclo: RTL and testbench
======================================

// Module: controle_multiciclo
// PURPOSE
//  Moore control FSM that sequences the multicycle RISC-V datapath. Drives the 4-bit estado bus
//  consumed by instruction fetch (instruction latched at the clock edge that ends FETCH), owns the
//  word-indexed PC, decodes the latched instruction and issues per-state register/memory/ALU enables.
//  Supports lw, sw, R-type (add/sub/xor/srl), I-type ALU (addi), beq; halts on all-zero word.
// PARAMETERS
//  PROG_LAST  8   last valid instruction index; fetch with pc > PROG_LAST goes to HALT
//  CNT_W      16  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-low reset (0 = reset)
//  instrucao    in   32     instruction from fetch; valid from DECODE until next FETCH
//  zero         in   1      ALU zero flag (rs1 - rs2 == 0), sampled in BRANCH
//  estado       out  4      current FSM state (encodings below)
//  pc           out  32     word index of current instruction
//  reg_write    out  1      register-file write enable
//  mem_read     out  1      data-memory read enable
//  mem_write    out  1      data-memory write enable
//  mem_to_reg   out  1      1 = write-back data from memory, 0 = from ALU
//  alu_src      out  1      1 = immediate operand B, 0 = rs2
//  alu_op       out  2      00 add, 01 sub (compare), 10 funct decode R, 11 funct decode I
//  halted       out  1      1 while in HALT
//  illegal      out  1      sticky: HALT entered due to unsupported opcode
//  instr_count  out  CNT_W  instructions retired since reset, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (rst=0, async): estado=FETCH(0000), pc=0, instr_count=0, illegal=0, opcode class cleared;
//   all enables 0. Deasserting reset: first FETCH cycle is the cycle after release edge.
//  States: FETCH 0000, DECODE 0001, MEM_ADDR 0010, MEM_READ 0011, MEM_WB 0100, MEM_WRITE 0101,
//   EXEC_R 0110, EXEC_I 0111, ALU_WB 1000, BRANCH 1001, HALT 1111. Other codes unreachable -> FETCH.
//  FETCH: if pc > PROG_LAST -> HALT, else -> DECODE (fetch latches instrucoes[pc] at this edge).
//  DECODE: on opcode[6:0]: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I;
//   1100011 -> BRANCH; instrucao==0 -> HALT (illegal stays 0); any other -> HALT, illegal<=1.
//   Opcode class registered in DECODE; later states use the register, not instrucao.
//  MEM_ADDR -> MEM_READ (lw) or MEM_WRITE (sw). MEM_READ -> MEM_WB. EXEC_R/EXEC_I -> ALU_WB.
//  Terminal states MEM_WB, MEM_WRITE, ALU_WB: pc<=pc+1, instr_count+1, -> FETCH.
//  BRANCH: imm={ins[31],ins[7],ins[30:25],ins[11:8],1'b0} sign-extended (byte offset);
//   zero=1: pc<=pc+(imm>>>2) (arithmetic), else pc<=pc+1; instr_count+1; -> FETCH.
//  PC arithmetic 32-bit modulo 2^32; no alignment check on imm[1].
//  Latency: beq 3 cycles, R/I/sw 4, lw 5 (counting FETCH).
//  Outputs decoded from estado (+opcode class), no extra cycle:
//   MEM_ADDR: alu_src=1, alu_op=00. MEM_READ: + mem_read=1. MEM_WB: + mem_read=1, mem_to_reg=1,
//   reg_write=1. MEM_WRITE: alu_src=1, alu_op=00, mem_write=1. EXEC_R: alu_op=10, alu_src=0.
//   EXEC_I: alu_op=11, alu_src=1. ALU_WB: same alu_op/alu_src as EXEC_x, reg_write=1.
//   BRANCH: alu_op=01, alu_src=0. FETCH/DECODE/HALT: all enables 0.
//  HALT: absorbing until reset; pc and instr_count frozen; halted=1.
//  Reset mid-instruction: aborts immediately, no partial write enable persists past reset edge.
// TESTING
//  1 Reset held then released, instrucao=0x00A00003 (lw) -> estado 0,1,2,3,4,0; reg_write only in 4;
//    pc 0->1 at end of MEM_WB; instr_count=1.
//  2 Program {lw,sw,sub,xor,addi,srl,beq x0,x0,+8,add,0}, zero=1 in BRANCH -> pc 6->8 skipping add,
//    DECODE of 0 -> HALT; instr_count=7, illegal=0, total cycles 5+4*5+3+2=30.
//  3 Same program, zero=0 -> pc 6->7, add executes, halts at pc=8; instr_count=8.
//  4 Opcode 1101111 (jal) in DECODE -> HALT next edge, illegal=1, pc unchanged, no enables.
//  5 PROG_LAST=1, two addi words -> after 2 retirements FETCH at pc=2 -> HALT, instr_count=2.
//  6 Assert rst during MEM_WRITE -> mem_write drops async, estado=0000, pc=0, instr_count=0.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Moore control FSM for the multicycle RISC-V datapath: owns the word-indexed PC, sequences
// fetch/decode/execute states and issues per-state datapath enables.
module controle_multiciclo #(
    parameter int unsigned PROG_LAST = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instrucao,
    input  logic             zero,
    output logic [3:0]       estado,
    output logic [31:0]      pc,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch    = 4'h0,
        StDecode   = 4'h1,
        StMemAddr  = 4'h2,
        StMemRead  = 4'h3,
        StMemWb    = 4'h4,
        StMemWrite = 4'h5,
        StExecR    = 4'h6,
        StExecI    = 4'h7,
        StAluWb    = 4'h8,
        StBranch   = 4'h9,
        StHalt     = 4'hF
    } state_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsLoad,
        ClsStore,
        ClsReg,
        ClsImm,
        ClsBranch
    } cls_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;

    logic [12:0] br_imm;
    logic [31:0] br_off;
    logic        unused_instr;

    // B-type byte offset; the arithmetic >>2 to a word offset is a sign-extended slice.
    assign br_imm       = {instrucao[31], instrucao[7], instrucao[30:25], instrucao[11:8], 1'b0};
    assign br_off       = {{21{br_imm[12]}}, br_imm[12:2]};
    assign unused_instr = ^instrucao[24:12];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            pc_q    <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        ill_d      = ill_q;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;

        case (state_q)
            StFetch: begin
                state_d = (pc_q > PROG_LAST) ? StHalt : StDecode;
            end
            StDecode: begin
                case (instrucao[6:0])
                    OpLoad: begin
                        cls_d   = ClsLoad;
                        state_d = StMemAddr;
                    end
                    OpStore: begin
                        cls_d   = ClsStore;
                        state_d = StMemAddr;
                    end
                    OpReg: begin
                        cls_d   = ClsReg;
                        state_d = StExecR;
                    end
                    OpImm: begin
                        cls_d   = ClsImm;
                        state_d = StExecI;
                    end
                    OpBranch: begin
                        cls_d   = ClsBranch;
                        state_d = StBranch;
                    end
                    default: begin
                        // An all-zero word is a clean end of program, not a fault.
                        cls_d   = ClsNone;
                        state_d = StHalt;
                        if (instrucao != 32'h0) ill_d = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src = 1'b1;
                state_d = (cls_q == ClsStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                alu_src  = 1'b1;
                mem_read = 1'b1;
                state_d  = StMemWb;
            end
            StMemWb: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                pc_d       = pc_q + 32'd1;
                cnt_d      = cnt_q + CNT_W'(1);
                state_d    = StFetch;
            end
            StMemWrite: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                pc_d      = pc_q + 32'd1;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = StFetch;
            end
            StExecR: begin
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                alu_op  = 2'b11;
                alu_src = 1'b1;
                state_d = StAluWb;
            end
            StAluWb: begin
                if (cls_q == ClsImm) begin
                    alu_op  = 2'b11;
                    alu_src = 1'b1;
                end else begin
                    alu_op = 2'b10;
                end
                reg_write = 1'b1;
                pc_d      = pc_q + 32'd1;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = StFetch;
            end
            StBranch: begin
                alu_op  = 2'b01;
                pc_d    = zero ? pc_q + br_off : pc_q + 32'd1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign estado      = state_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign illegal     = ill_q;
    assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: an instruction-level program model expands each program into an
// expected per-cycle trace, which is compared against the DUT cycle by cycle.
module tb_controle_multiciclo;

    localparam int LEN = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instrucao;
    logic        zero = 1'b0;
    logic [3:0]  estado;
    logic [31:0] pc;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [1:0]  alu_op;
    logic        halted, illegal;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [16];
    int          zmode;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  ctrl;
        logic [31:0] pc;
        logic [15:0] cnt;
        logic        ill;
        logic        z;
    } exp_t;
    exp_t exp_q[$];

    controle_multiciclo #(.PROG_LAST(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instrucao(instrucao), .zero(zero), .estado(estado), .pc(pc),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Fetch unit: the word at pc is visible from DECODE until the next FETCH.
    always_comb instrucao = (pc <= 32'd8) ? prog[pc[3:0]] : 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}
    task automatic push(input logic [3:0] st, input logic [6:0] c, input logic [31:0] p,
                        input logic [15:0] n, input logic ill, input logic z);
        exp_t e;
        e.st = st; e.ctrl = c; e.pc = p; e.cnt = n; e.ill = ill; e.z = z;
        exp_q.push_back(e);
    endtask

    function automatic logic pick_zero();
        if (zmode == 1) return 1'b1;
        if (zmode == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic build_trace();
        logic [31:0] p = 0;
        logic [15:0] n = 0;
        logic [31:0] ins;
        logic [12:0] imm;
        logic        z;
        logic        done = 0;
        exp_q.delete();
        while (exp_q.size() < LEN && !done) begin
            if (p > 32'd8) begin
                push(4'h0, 7'h00, p, n, 1'b0, pick_zero());
                done = 1;
            end else begin
                ins = prog[p[3:0]];
                push(4'h0, 7'h00, p, n, 1'b0, pick_zero());
                push(4'h1, 7'h00, p, n, 1'b0, pick_zero());
                case (ins[6:0])
                    7'b0000011: begin
                        push(4'h2, 7'b0000100, p, n, 1'b0, pick_zero());
                        push(4'h3, 7'b0100100, p, n, 1'b0, pick_zero());
                        push(4'h4, 7'b1101100, p, n, 1'b0, pick_zero());
                        p = p + 1; n = n + 1;
                    end
                    7'b0100011: begin
                        push(4'h2, 7'b0000100, p, n, 1'b0, pick_zero());
                        push(4'h5, 7'b0010100, p, n, 1'b0, pick_zero());
                        p = p + 1; n = n + 1;
                    end
                    7'b0110011: begin
                        push(4'h6, 7'b0000010, p, n, 1'b0, pick_zero());
                        push(4'h8, 7'b1000010, p, n, 1'b0, pick_zero());
                        p = p + 1; n = n + 1;
                    end
                    7'b0010011: begin
                        push(4'h7, 7'b0000111, p, n, 1'b0, pick_zero());
                        push(4'h8, 7'b1000111, p, n, 1'b0, pick_zero());
                        p = p + 1; n = n + 1;
                    end
                    7'b1100011: begin
                        z = pick_zero();
                        push(4'h9, 7'b0000001, p, n, 1'b0, z);
                        imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                        if (z) p = p + 32'($signed(imm) >>> 2);
                        else   p = p + 1;
                        n = n + 1;
                    end
                    default: begin
                        done = 1;
                        while (exp_q.size() < LEN)
                            push(4'hF, 7'h00, p, n, ins != 32'h0, pick_zero());
                    end
                endcase
            end
        end
        while (exp_q.size() < LEN) begin
            exp_t last = exp_q[exp_q.size() - 1];
            push(4'hF, 7'h00, last.pc, last.cnt, last.ill, pick_zero());
        end
        while (exp_q.size() > LEN) void'(exp_q.pop_back());
    endtask

    function automatic logic [31:0] beq_word(input int byte_off);
        logic [12:0] imm = 13'(byte_off);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic random_prog();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] r = $urandom;
            case ($urandom_range(0, 15))
                0, 1, 2: prog[i] = {r[31:7], 7'b0000011};
                3, 4:    prog[i] = {r[31:7], 7'b0100011};
                5, 6, 7, 14: prog[i] = {r[31:7], 7'b0110011};
                8, 9, 15:    prog[i] = {r[31:7], 7'b0010011};
                10, 11:  prog[i] = beq_word(2 * ($urandom_range(0, 22) - 8));
                12:      prog[i] = {r[31:7], 7'b1101111};
                default: prog[i] = (r[0]) ? 32'h0 : {r[31:7], 7'b0000000};
            endcase
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_estado", 64'(estado), 64'h0);
        check_eq("rst_pc", 64'(pc), 64'h0);
        check_eq("rst_cnt", 64'(instr_count), 64'h0);
        check_eq("rst_ill", 64'(illegal), 64'h0);
        check_eq("rst_ctrl", 64'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}),
                 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_trace(input int run);
        build_trace();
        reset_dut();
        for (int i = 0; i < LEN; i++) begin
            exp_t e = exp_q[i];
            zero = e.z;
            #1;
            check_eq($sformatf("r%0d_c%0d_estado", run, i), 64'(estado), 64'(e.st));
            check_eq($sformatf("r%0d_c%0d_pc", run, i), 64'(pc), 64'(e.pc));
            check_eq($sformatf("r%0d_c%0d_cnt", run, i), 64'(instr_count), 64'(e.cnt));
            check_eq($sformatf("r%0d_c%0d_ctrl", run, i),
                     64'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}),
                     64'(e.ctrl));
            check_eq($sformatf("r%0d_c%0d_halted", run, i), 64'(halted), 64'(e.st == 4'hF));
            check_eq($sformatf("r%0d_c%0d_illegal", run, i), 64'(illegal), 64'(e.ill));
            @(negedge clk);
        end
    endtask

    task automatic fixed_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = 32'h00A00003;
        prog[1] = 32'h00112223;
        prog[2] = 32'h40208033;
        prog[3] = 32'h0020C033;
        prog[4] = 32'h00500093;
        prog[5] = 32'h0020D033;
        prog[6] = beq_word(8);
        prog[7] = 32'h00208033;
        prog[8] = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        fixed_prog(); zmode = 1; run_trace(0);
        fixed_prog(); zmode = 2; run_trace(1);
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = 32'h0000006F; zmode = 0; run_trace(2);
        prog[0] = 32'h00A00003; run_trace(3);
        for (int i = 0; i < 9; i++) prog[i] = 32'h00108093;
        run_trace(4);
        for (int r = 5; r < 17; r++) begin
            random_prog();
            run_trace(r);
        end

        // Reset asserted mid-store must kill mem_write immediately, without waiting for a clock.
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = 32'h00108093;
        prog[1] = 32'h00112223;
        zmode = 0;
        reset_dut();
        for (int k = 0; k < 20 && estado != 4'h5; k++) @(negedge clk);
        check_eq("mw_reached", 64'(estado), 64'h5);
        check_eq("mw_active", 64'(mem_write), 64'h1);
        #2 rst = 1'b0;
        #1;
        check_eq("mw_rst_memw", 64'(mem_write), 64'h0);
        check_eq("mw_rst_estado", 64'(estado), 64'h0);
        check_eq("mw_rst_pc", 64'(pc), 64'h0);
        check_eq("mw_rst_cnt", 64'(instr_count), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
